// File: rtl/mem_sys_pkg.sv
// ---------------------------------------------------------------------------
// mem_sys_pkg
// Shared definitions for the main-memory port arbiter:
//   - state_e     : arbiter FSM encoding (IDLE / ISSUE / WAIT)
//   - DEF_ADDR_W  : default address width
//   - DEF_DATA_W  : default data width
//   - gnt_idx_w() : width of a grant index for a given number of ports
// ---------------------------------------------------------------------------
package mem_sys_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // clog2 of the port count, never narrower than one bit.
    function automatic int gnt_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// ---------------------------------------------------------------------------
// arb_pick
// Purely combinational winner selection among eligible requestors.
//   eligible_i  : per-port eligibility vector
//   ptr_i       : round-robin search start (ignored for fixed priority)
//   grant_o     : one-hot grant, all zero when nothing is eligible
//   grant_idx_o : binary index of the granted port
// Build option: ARB_RR_EN selects round-robin search starting at ptr_i;
// without it the lowest eligible index wins.
// ---------------------------------------------------------------------------
module arb_pick
    import mem_sys_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = gnt_idx_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] eligible_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic [IDX_W-1:0]     grant_idx_o
);

`ifdef ARB_RR_EN
    // Walk the ports starting at ptr_i, wrapping at NUM_PORTS-1; the first
    // eligible port found wins.
    always_comb begin
        int   cand;
        logic found;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = (int'(ptr_i) + k) % NUM_PORTS;
            if (!found && eligible_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = IDX_W'(cand);
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    // Scan from the top down so the lowest eligible index overwrites last.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (eligible_i[k]) begin
                grant_o     = '0;
                grant_o[k]  = 1'b1;
                grant_idx_o = IDX_W'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Arbitrates NUM_PORTS requestors (0 = data, 1 = instruction, others spare)
// onto a single main-memory port with one transaction outstanding. Each port
// owns a one-entry response slot with valid/ready; flush[i] squashes port i's
// slot and any in-flight read belonging to it.
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   req_valid/ready/we    : per-port request handshake and direction
//   req_addr/req_wdata    : packed per-port command fields
//   rsp_valid/ready/data  : per-port response slot
//   flush                 : per-port squash
//   mem_req/we/addr/wdata : command to memory, held until mem_ack
//   mem_ack               : memory accepted the command
//   mem_rvalid/mem_rdata  : transaction completion / read data
// Build option: define ARB_RR_EN for round-robin arbitration (default is
// fixed priority, lowest index first).
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_sys_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_valid,
    output logic [NUM_PORTS-1:0]        req_ready,
    input  logic [NUM_PORTS-1:0]        req_we,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]        rsp_valid,
    input  logic [NUM_PORTS-1:0]        rsp_ready,
    output logic [NUM_PORTS*DATA_W-1:0] rsp_data,
    input  logic [NUM_PORTS-1:0]        flush,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_ack,
    input  logic                        mem_rvalid,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int IDX_W = gnt_idx_w(NUM_PORTS);

    state_e             state_q, state_d;
    logic               cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0]  cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]  cmd_wdata_q, cmd_wdata_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic               drop_q, drop_d;

    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] grant;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     rr_ptr;
    logic                 accept;
    logic                 capture;

    logic [ADDR_W-1:0] req_addr_arr  [NUM_PORTS];
    logic [DATA_W-1:0] req_wdata_arr [NUM_PORTS];

    // A port may only win if its slot is empty or being drained this cycle,
    // so a captured response can never overwrite an unconsumed one.
    assign eligible = req_valid & (~rsp_valid | rsp_ready);

    arb_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .eligible_i  (eligible),
        .ptr_i       (rr_ptr),
        .grant_o     (grant),
        .grant_idx_o (pick_idx)
    );

    assign accept = |req_ready;

    // Read data lands in the granted slot only when nothing squashed it,
    // including a flush arriving in the completion cycle itself.
    assign capture = (state_q == WAIT) && mem_rvalid && !cmd_we_q &&
                     !drop_q && !flush[gnt_idx_q];

`ifdef ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    // Pointer holds the next search start: one past the last winner.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (pick_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : pick_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rr_ptr = rr_ptr_q;
`else
    assign rr_ptr = '0;
`endif

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state and command capture
    always_comb begin
        state_d     = state_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        gnt_idx_d   = gnt_idx_q;
        drop_d      = drop_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = ISSUE;
                    cmd_we_d    = req_we[pick_idx];
                    cmd_addr_d  = req_addr_arr[pick_idx];
                    cmd_wdata_d = req_wdata_arr[pick_idx];
                    gnt_idx_d   = pick_idx;
                    // A flush coinciding with the new request belongs to the
                    // old context, so the fresh transaction starts clean.
                    drop_d      = 1'b0;
                end
            end
            ISSUE: begin
                if (flush[gnt_idx_q]) begin
                    drop_d = 1'b1;
                end
                if (mem_ack) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (flush[gnt_idx_q]) begin
                    drop_d = 1'b1;
                end
                if (mem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            gnt_idx_q   <= '0;
            drop_q      <= 1'b0;
        end else begin
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            gnt_idx_q   <= gnt_idx_d;
            drop_q      <= drop_d;
        end
    end

    // FSM: outputs. req_ready is also gated by rst so that every output reads
    // zero while reset is held, even with requests pending.
    always_comb begin
        req_ready = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst && (state_q == IDLE)) begin
            req_ready = grant;
        end
        if (state_q == ISSUE) begin
            mem_req   = 1'b1;
            mem_we    = cmd_we_q;
            mem_addr  = cmd_addr_q;
            mem_wdata = cmd_wdata_q;
        end
    end

    // Per-port request unpacking and response slots.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        logic              valid_q, valid_d;
        logic [DATA_W-1:0] data_q, data_d;

        assign req_addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign req_wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];

        // Capture wins over a same-cycle drain, leaving the slot full with
        // the new data; flush empties the slot otherwise.
        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (capture && (gnt_idx_q == IDX_W'(gi))) begin
                valid_d = 1'b1;
                data_d  = mem_rdata;
            end else if (flush[gi]) begin
                valid_d = 1'b0;
            end else if (valid_q && rsp_ready[gi]) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        assign rsp_valid[gi]                 = valid_q;
        assign rsp_data[gi*DATA_W +: DATA_W] = data_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter with three ports. A transaction
// level reference model (one outstanding command, per-port slot contents)
// predicts grants, the memory command and the response slots every cycle.
// Directed scenarios cover latency, arbitration, back-pressure, flush and
// reset; a randomized phase follows. Define ARB_RR_EN to check round-robin.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP-1:0]   req_valid, req_ready, req_we, rsp_valid, rsp_ready, flush;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_wdata, rsp_data;
    logic            mem_req, mem_we, mem_ack, mem_rvalid;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: one outstanding transaction plus slot contents.
    bit          m_busy, m_acked, m_we, m_drop;
    int          m_port, m_last;
    logic [31:0] m_addr, m_wdata;
    bit          e_valid [NP];
    logic [31:0] e_data  [NP];

    // Values seen on the DUT in the most recent step.
    logic [NP-1:0]    seen_rdy, seen_rv;
    logic [NP*DW-1:0] seen_rdata;
    logic             seen_mreq, seen_mwe;
    logic [AW-1:0]    seen_maddr;
    logic [DW-1:0]    seen_mwdata;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_acked = 0; m_we = 0; m_drop = 0; m_port = 0;
        m_last = NP - 1;
        for (int i = 0; i < NP; i++) begin
            e_valid[i] = 0;
            e_data[i]  = '0;
        end
    endtask

    function automatic int pick_winner(input logic [NP-1:0] elig);
`ifdef ARB_RR_EN
        for (int k = 1; k <= NP; k++) begin
            int p;
            p = (m_last + k) % NP;
            if (elig[p]) return p;
        end
`else
        for (int p = 0; p < NP; p++) begin
            if (elig[p]) return p;
        end
`endif
        return -1;
    endfunction

    function automatic bit slots_any();
        bit r = 0;
        for (int i = 0; i < NP; i++) r |= e_valid[i];
        return r;
    endfunction

    // Called just after a rising edge with inputs already driven: compares
    // the DUT against the model mid-cycle, advances the model across the
    // next edge, and returns just after that edge.
    task automatic step();
        logic [NP-1:0] elig, exp_rdy, exp_rv;
        int w;
        bit cap;
        #3;
        seen_rdy = req_ready; seen_rv = rsp_valid; seen_rdata = rsp_data;
        seen_mreq = mem_req; seen_mwe = mem_we; seen_maddr = mem_addr; seen_mwdata = mem_wdata;
        for (int i = 0; i < NP; i++) elig[i] = req_valid[i] & (~e_valid[i] | rsp_ready[i]);
        w = m_busy ? -1 : pick_winner(elig);
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        check_eq("req_ready", req_ready, exp_rdy);
        check_eq("mem_req", mem_req, m_busy && !m_acked);
        if (m_busy && !m_acked) begin
            check_eq("mem_we", mem_we, m_we);
            check_eq("mem_addr", mem_addr, m_addr);
            check_eq("mem_wdata", mem_wdata, m_wdata);
        end
        for (int i = 0; i < NP; i++) exp_rv[i] = e_valid[i];
        check_eq("rsp_valid", rsp_valid, exp_rv);
        for (int i = 0; i < NP; i++) begin
            if (e_valid[i]) check_eq("rsp_data", rsp_data[i*DW +: DW], e_data[i]);
        end
        for (int i = 0; i < NP; i++) begin
            cap = m_busy && m_acked && mem_rvalid && (m_port == i) && !m_we && !m_drop && !flush[i];
            if (cap) begin
                e_valid[i] = 1; e_data[i] = mem_rdata;
            end else if (flush[i]) begin
                e_valid[i] = 0;
            end else if (e_valid[i] && rsp_ready[i]) begin
                e_valid[i] = 0;
            end
        end
        if (m_busy && flush[m_port]) m_drop = 1;
        if (w >= 0) begin
            m_busy = 1; m_acked = 0; m_port = w; m_drop = 0; m_last = w;
            m_we = req_we[w]; m_addr = req_addr[w*AW +: AW]; m_wdata = req_wdata[w*DW +: DW];
        end else if (m_busy && !m_acked && mem_ack) begin
            m_acked = 1;
        end else if (m_busy && m_acked && mem_rvalid) begin
            m_busy = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // Memory that answers as fast as the protocol allows.
    task automatic auto_mem();
        mem_ack    = m_busy && !m_acked;
        mem_rvalid = m_busy && m_acked;
        mem_rdata  = $urandom;
    endtask

    task automatic quiesce();
        int n = 0;
        req_valid = '0; flush = '0; rsp_ready = '1;
        while ((m_busy || slots_any()) && n < 20) begin
            auto_mem();
            step();
            n++;
        end
        mem_ack = 0; mem_rvalid = 0;
        rsp_ready = '0;
        #1;
        check_eq("quiesce_rsp_valid", rsp_valid, '0);
        check_eq("quiesce_mem_req", mem_req, 1'b0);
    endtask

    task automatic set_req(input int p, input bit we, input logic [31:0] a, input logic [31:0] wd);
        req_valid[p] = 1'b1;
        req_we[p]    = we;
        req_addr[p*AW +: AW]  = a;
        req_wdata[p*DW +: DW] = wd;
    endtask

    // Read on port p with fastest memory response; slot must show d at T+3.
    task automatic single_read(input int p, input logic [31:0] a, input logic [31:0] d);
        logic [NP-1:0] oh;
        oh = '0; oh[p] = 1'b1;
        req_valid = '0; set_req(p, 1'b0, a, 32'h0);
        step();
        check_eq("sr_accept", seen_rdy, oh);
        req_valid = '0; mem_ack = 1;
        step();
        check_eq("sr_mem_req", seen_mreq, 1'b1);
        check_eq("sr_mem_addr", seen_maddr, a);
        mem_ack = 0; mem_rvalid = 1; mem_rdata = d;
        step();
        check_eq("sr_not_yet", seen_rv, '0);
        mem_rvalid = 0;
        step();
        check_eq("sr_rsp_valid", seen_rv, oh);
        check_eq("sr_rsp_data", seen_rdata[p*DW +: DW], d);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NP-1:0] prev_g;
        int n, p1_grants;

        rst = 0; req_valid = '1; req_we = '0; req_addr = '0; req_wdata = '0;
        rsp_ready = '0; flush = '0; mem_ack = 0; mem_rvalid = 0; mem_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_req_ready", req_ready, '0);
        check_eq("reset_rsp_valid", rsp_valid, '0);
        check_eq("reset_mem_req", mem_req, 1'b0);
        req_valid = '0;
        rst = 1;
        step();

        // Single read on port 1.
        quiesce();
        single_read(1, 32'h100, 32'hDEADBEEF);

        // Ports 0 and 1 request continuously.
        quiesce();
        rsp_ready = '1;
        prev_g = '0;
        for (int c = 0; c < 24; c++) begin
            set_req(0, 1'b0, 32'h1000 + c, 32'h0);
            set_req(1, 1'b0, 32'h2000 + c, 32'h0);
            auto_mem();
            step();
            if (seen_rdy != '0) begin
`ifdef ARB_RR_EN
                if (prev_g != '0) check_eq("rr_alternate", seen_rdy == prev_g, 1'b0);
`else
                check_eq("fixed_prio", seen_rdy, 3'b001);
`endif
                prev_g = seen_rdy;
            end
        end

        // Full port 0 slot blocks port 0 while port 1 keeps being served.
        quiesce();
        req_valid = '0; set_req(0, 1'b0, 32'h300, 32'h0);
        n = 0;
        while (!e_valid[0] && n < 20) begin
            auto_mem();
            step();
            if (m_busy) req_valid = '0;
            n++;
        end
        check_eq("bp_slot0_full", rsp_valid[0], 1'b1);
        rsp_ready = 3'b010;
        p1_grants = 0;
        for (int c = 0; c < 12; c++) begin
            set_req(0, 1'b0, 32'h304, 32'h0);
            set_req(1, 1'b0, 32'h400 + c, 32'h0);
            auto_mem();
            step();
            check_eq("bp_port0_blocked", seen_rdy[0], 1'b0);
            if (seen_rdy[1]) p1_grants++;
        end
        check_eq("bp_port1_served", p1_grants > 0, 1'b1);
        req_valid = '0; set_req(0, 1'b0, 32'h304, 32'h0);
        n = 0;
        while (m_busy && n < 20) begin
            auto_mem();
            step();
            n++;
        end
        rsp_ready = 3'b011;
        set_req(1, 1'b0, 32'h500, 32'h0);
        mem_ack = 0; mem_rvalid = 0;
        step();
        check_eq("bp_port0_released", seen_rdy, 3'b001);

        // Flush of port 1 while its read is in WAIT.
        quiesce();
        req_valid = '0; set_req(1, 1'b0, 32'h200, 32'h0);
        step();
        req_valid = '0; mem_ack = 1;
        step();
        mem_ack = 0; flush = 3'b010;
        step();
        flush = '0; mem_rvalid = 1; mem_rdata = 32'h1234;
        step();
        mem_rvalid = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq("flush_no_rsp", seen_rv[1], 1'b0);
        end
        single_read(1, 32'h104, 32'hCAFEF00D);

        // Port 0 write held until ack, flushed in WAIT, still completes.
        quiesce();
        req_valid = '0; set_req(0, 1'b1, 32'h40, 32'h55);
        step();
        check_eq("wr_accept", seen_rdy, 3'b001);
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            mem_ack = (c == 3);
            step();
            check_eq("wr_hold_req", seen_mreq, 1'b1);
            check_eq("wr_hold_we", seen_mwe, 1'b1);
            check_eq("wr_hold_addr", seen_maddr, 32'h40);
            check_eq("wr_hold_wdata", seen_mwdata, 32'h55);
        end
        mem_ack = 0; flush = 3'b001;
        step();
        flush = '0; mem_rvalid = 1; mem_rdata = 32'hFFFF0000;
        step();
        mem_rvalid = 0;
        for (int c = 0; c < 2; c++) begin
            step();
            check_eq("wr_no_rsp", seen_rv, '0);
            check_eq("wr_done_idle", seen_mreq, 1'b0);
        end

        // Reset asserted while a command sits in ISSUE.
        quiesce();
        single_read(2, 32'h600, 32'hA5A5A5A5);
        req_valid = '0; set_req(0, 1'b0, 32'h700, 32'h0);
        step();
        check_eq("rst_pre_issue", mem_req, 1'b1);
        rst = 0;
        #1;
        check_eq("rst_mem_req", mem_req, 1'b0);
        check_eq("rst_req_ready", req_ready, '0);
        check_eq("rst_rsp_valid", rsp_valid, '0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1; req_valid = '0; mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
        step();
        mem_rvalid = 0;
        step();
        check_eq("rst_stray_rvalid", seen_rv, '0);

        // Randomized traffic.
        quiesce();
        for (int c = 0; c < 2000; c++) begin
            for (int p = 0; p < NP; p++) begin
                req_valid[p] = ($urandom_range(0, 2) != 0);
                req_we[p]    = ($urandom_range(0, 3) == 0);
                req_addr[p*AW +: AW]  = $urandom;
                req_wdata[p*DW +: DW] = $urandom;
                rsp_ready[p] = ($urandom_range(0, 2) != 0);
                flush[p]     = ($urandom_range(0, 11) == 0);
            end
            mem_ack    = m_busy && !m_acked && ($urandom_range(0, 2) != 0);
            mem_rvalid = (m_busy && m_acked && ($urandom_range(0, 2) != 0)) ||
                         (!m_busy && ($urandom_range(0, 15) == 0));
            mem_rdata  = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
